gpu_ram_arb: RTL and testbench

- Parametrised successor to the GPU local RAM: single-port synchronous RAM, DEPTH words x DW bits, shared by two requesters.
  - GPU execute port.
  - External bus port, which carries the tristate output-enable.
- Adds byte-lane writes, registered reads, fixed-priority arbitration with a starvation guard, and optional per-byte parity.
- Sits between GPU core and system bus; replaces a fixed 1K x 32 local RAM.

---
 rtl/gpu_ram_arb.sv | 119 +++++++++++
 tb/tb_gpu_ram_arb.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/gpu_ram_arb.sv
// Shared single-port RAM (DEPTH x DW) for GPU and bus, with byte lanes, registered reads and fixed-priority arbitration.
// The bus requester has a starvation guard. Defining GPU_RAM_PARITY_EN adds even parity per byte lane and a sticky par_err.

module gpu_ram_lane #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          perr
);
`ifdef GPU_RAM_PARITY_EN
  // bit 8 holds even parity over the stored byte
  logic [8:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[addr] <= {^wdata, wdata};
  assign rdata = mem[addr][7:0];
  assign perr  = ^mem[addr];
`else
  logic [7:0] mem [2**AW];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
  assign perr  = 1'b0;
`endif
endmodule

module gpu_ram_arb #(
  parameter int DW         = 32,
  parameter int AW         = 10,
  parameter int STARVE_MAX = 4
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            gpu_req,
  input  logic            gpu_we,
  input  logic [AW-1:0]   gpu_addr,
  input  logic [DW-1:0]   gpu_wdata,
  input  logic [DW/8-1:0] gpu_be,
  output logic            gpu_gnt,
  output logic            gpu_rvalid,
  output logic [DW-1:0]   gpu_rdata,
  input  logic            bus_req,
  input  logic            bus_we,
  input  logic [AW-1:0]   bus_addr,
  input  logic [DW-1:0]   bus_wdata,
  input  logic [DW/8-1:0] bus_be,
  output logic            bus_gnt,
  output logic            bus_rvalid,
  output logic [DW-1:0]   bus_rdata,
  output logic            bus_data_oe,
  output logic            par_err,
  input  logic            par_clr
);
  localparam int NL = DW / 8;

  typedef struct packed {
    logic                 we;
    logic [AW-1:0]        addr;
    logic [NL-1:0][7:0]   wdata;
    logic [NL-1:0]        be;
  } req_t;

  req_t               gpu_r, bus_r, acc;
  logic [3:0]         starve;
  logic               force_bus, acc_wr, acc_rd;
  logic [NL-1:0][7:0] mem_rdata;
  logic [NL-1:0]      lane_perr;

  assign gpu_r = {gpu_we, gpu_addr, gpu_wdata, gpu_be};
  assign bus_r = {bus_we, bus_addr, bus_wdata, bus_be};

  // Grants are gated by reset so nothing is granted while it is held
  always_comb begin
    force_bus = bus_req && (starve == 4'(STARVE_MAX));
    gpu_gnt   = ~reset & gpu_req & ~force_bus;
    bus_gnt   = ~reset & bus_req & (~gpu_req | force_bus);
    acc       = bus_gnt ? bus_r : gpu_r;
    acc_wr    = (gpu_gnt | bus_gnt) & acc.we;
    acc_rd    = (gpu_gnt | bus_gnt) & ~acc.we;
  end

  always_ff @(posedge sys_clk or posedge reset)
    if (reset)                    starve <= '0;
    else if (!bus_req || bus_gnt) starve <= '0;
    else if (starve != 4'hF)      starve <= starve + 4'd1;

  for (genvar i = 0; i < NL; i++) begin : g_lane
    gpu_ram_lane #(.AW(AW)) u_lane (
      .clk   (sys_clk),
      .we    (acc_wr & acc.be[i]),
      .addr  (acc.addr),
      .wdata (acc.wdata[i]),
      .rdata (mem_rdata[i]),
      .perr  (lane_perr[i])
    );
  end

  always_ff @(posedge sys_clk or posedge reset)
    if (reset) begin
      gpu_rvalid <= 1'b0;
      bus_rvalid <= 1'b0;
      gpu_rdata  <= '0;
      bus_rdata  <= '0;
      par_err    <= 1'b0;
    end else begin
      gpu_rvalid <= gpu_gnt & ~gpu_we;
      bus_rvalid <= bus_gnt & ~bus_we;
      if (gpu_gnt & ~gpu_we) gpu_rdata <= mem_rdata;
      if (bus_gnt & ~bus_we) bus_rdata <= mem_rdata;
      // a new error outranks a simultaneous clear
      if (acc_rd && |lane_perr) par_err <= 1'b1;
      else if (par_clr)         par_err <= 1'b0;
    end

  assign bus_data_oe = bus_rvalid;
endmodule

// File: tb/tb_gpu_ram_arb.sv
// Directed bench for gpu_ram_arb: stimulus pushes expected read data, a negedge monitor pops and checks.
module tb_gpu_ram_arb;
  logic        sys_clk = 0, reset = 1;
  logic        gpu_req = 0, gpu_we = 0, bus_req = 0, bus_we = 0, par_clr = 0;
  logic [9:0]  gpu_addr = 0, bus_addr = 0;
  logic [31:0] gpu_wdata = 0, bus_wdata = 0;
  logic [3:0]  gpu_be = 0, bus_be = 0;
  logic        gpu_gnt, gpu_rvalid, bus_gnt, bus_rvalid, bus_data_oe, par_err;
  logic [31:0] gpu_rdata, bus_rdata;

`ifdef GPU_RAM_PARITY_EN
  localparam logic PAR = 1'b1;
`else
  localparam logic PAR = 1'b0;
`endif

  typedef struct { logic [31:0] data; int due; } exp_t;
  exp_t gq[$], bq[$];
  logic [31:0] gexp = 0, bexp = 0;
  int cyc = 0, checks = 0, errors = 0;

  gpu_ram_arb #(.DW(32), .AW(10), .STARVE_MAX(4)) dut (
    .sys_clk(sys_clk), .reset(reset),
    .gpu_req(gpu_req), .gpu_we(gpu_we), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata), .gpu_be(gpu_be),
    .gpu_gnt(gpu_gnt), .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_data_oe(bus_data_oe),
    .par_err(par_err), .par_clr(par_clr)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // monitor
  always @(negedge sys_clk) begin
    exp_t e;
    checks++;
    if (bus_data_oe !== bus_rvalid) begin
      errors++;
      $display("FAIL oe: bus_data_oe=%b want %b", bus_data_oe, bus_rvalid);
    end
    if (gpu_rvalid === 1'b1) begin
      checks++;
      if (gq.size() == 0) begin
        errors++;
        $display("FAIL gpu_rd: unexpected rvalid data=%h at cycle %0d", gpu_rdata, cyc);
      end else begin
        e = gq.pop_front();
        if (gpu_rdata !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL gpu_rd: got %h at cycle %0d, want %h at cycle %0d", gpu_rdata, cyc, e.data, e.due);
        end
      end
    end
    if (bus_rvalid === 1'b1) begin
      checks++;
      if (bq.size() == 0) begin
        errors++;
        $display("FAIL bus_rd: unexpected rvalid data=%h at cycle %0d", bus_rdata, cyc);
      end else begin
        e = bq.pop_front();
        if (bus_rdata !== e.data || cyc != e.due) begin
          errors++;
          $display("FAIL bus_rd: got %h at cycle %0d, want %h at cycle %0d", bus_rdata, cyc, e.data, e.due);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  // one cycle: check grants at negedge, queue expected reads, return just after the edge
  task automatic cyc_chk(input logic eg, input logic eb);
    @(negedge sys_clk);
    chk("gnt", {gpu_gnt, bus_gnt}, {eg, eb});
    if (gpu_gnt && !gpu_we) gq.push_back('{gexp, cyc + 1});
    if (bus_gnt && !bus_we) bq.push_back('{bexp, cyc + 1});
    @(posedge sys_clk); #1;
  endtask

  task automatic gpu_acc(input logic we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    gpu_req = 1; gpu_we = we; gpu_addr = a; gpu_wdata = d; gpu_be = be; gexp = d;
    cyc_chk(1, 0);
    gpu_req = 0;
  endtask

  task automatic bus_acc(input logic we, input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    bus_req = 1; bus_we = we; bus_addr = a; bus_wdata = d; bus_be = be; bexp = d;
    cyc_chk(0, 1);
    bus_req = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_chk(0, 0);
  endtask

  initial begin
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst_ctl", {gpu_gnt, bus_gnt, gpu_rvalid, bus_rvalid, bus_data_oe, par_err}, 6'b0);
    chk("rst_data", {gpu_rdata, bus_rdata}, 64'h0);
    @(posedge sys_clk); #1 reset = 0;

    // GPU write then read; be=0 write is a no-op that still takes the grant
    gpu_acc(1, 10'h005, 32'hDEADBEEF, 4'hF);
    gpu_acc(0, 10'h005, 32'hDEADBEEF, 4'h0);
    gpu_acc(1, 10'h005, 32'h00000000, 4'h0);
    gpu_acc(0, 10'h005, 32'hDEADBEEF, 4'hF);
    idle(2);

    // bus byte-lane merge at the top address
    bus_acc(1, 10'h3FF, 32'h11223344, 4'hF);
    bus_acc(1, 10'h3FF, 32'h0000AA00, 4'b0010);
    bus_acc(0, 10'h3FF, 32'h1122AA44, 4'h0);
    idle(2);

    // back-to-back GPU reads
    for (int i = 0; i < 4; i++) gpu_acc(1, 10'(i), 32'hA5000000 | 32'(i * 17), 4'hF);
    gpu_acc(0, 10'h000, 32'hA5000000, 4'h0);
    gpu_acc(0, 10'h001, 32'hA5000011, 4'h0);
    gpu_acc(0, 10'h002, 32'hA5000022, 4'h0);
    gpu_acc(0, 10'h003, 32'hA5000033, 4'h0);
    idle(2);

    // starvation guard: bus forced through every 5th cycle
    gpu_req = 1; gpu_we = 0; gpu_addr = 10'h005; gexp = 32'hDEADBEEF;
    bus_req = 1; bus_we = 0; bus_addr = 10'h3FF; bexp = 32'h1122AA44;
    for (int k = 0; k < 15; k++) cyc_chk((k % 5) != 4, (k % 5) == 4);
    gpu_req = 0; bus_req = 0;
    idle(2);

    // parity: corrupt the stored parity bit of lane 2, data itself unchanged
    gpu_acc(1, 10'h010, 32'hCAFEF00D, 4'hF);
`ifdef GPU_RAM_PARITY_EN
    dut.g_lane[2].u_lane.mem[10'h010][8] = ~dut.g_lane[2].u_lane.mem[10'h010][8];
`endif
    gpu_acc(0, 10'h010, 32'hCAFEF00D, 4'h0);
    @(negedge sys_clk);
    chk("par_set", par_err, PAR);
    @(posedge sys_clk); #1 par_clr = 1;
    @(posedge sys_clk); #1 par_clr = 0;
    @(negedge sys_clk);
    chk("par_clr", par_err, 0);
    @(posedge sys_clk); #1;

    // reset lands between read grant and rvalid delivery
    bus_req = 1; bus_we = 0; bus_addr = 10'h005;
    @(negedge sys_clk);
    chk("rst_mid_gnt", bus_gnt, 1);
    @(posedge sys_clk); #1 reset = 1;
    @(negedge sys_clk);
    chk("rst_mid_out", {bus_rvalid, bus_data_oe, bus_gnt, gpu_rvalid}, 4'b0);
    chk("rst_mid_data", {bus_rdata, gpu_rdata}, 64'h0);
    bus_req = 0;
    @(posedge sys_clk); #1 reset = 0;
    idle(3);

    chk("queues_drained", gq.size() + bq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
